// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: the arbiter FSM state
// encoding, the transmitter status bit layout and the requester count.
package uart_pkg;

  // Number of byte sources sharing the transmitter.
  localparam int unsigned NUM_REQ = 2;

  // Bit of the transmitter status word that reports "transmit buffer full".
  localparam int unsigned TXBF_BIT = 6;

  // Width of the post-write settle counter; it covers SETTLE_CYC values 1..15.
  localparam int unsigned CNT_W = 4;

  // Write-sequencer states: wait for a byte, raise EN, drop EN (write cycle),
  // then wait for TXBF to become trustworthy again.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EN_HI  = 2'd1,
    ST_EN_LO  = 2'd2,
    ST_SETTLE = 2'd3
  } tx_state_e;

  // One-hot accept vector for a requester index.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector with packet lock. While locked, only the
// current owner can be selected; otherwise the pointer wins ties and a lone
// valid requester wins regardless of the pointer.
module rr_arb2
  import uart_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               ptr,
  input  logic               lock,
  input  logic               owner,
  output logic               sel_valid,
  output logic               sel_idx
);

  // Pick the requester to serve this cycle.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
    sel_valid = 1'b0;
    sel_idx   = ptr;
    if (lock) begin
      sel_idx   = owner;
      sel_valid = valid[owner];
    end else if (valid[ptr]) begin
      sel_valid = 1'b1;
      sel_idx   = ptr;
    end else if (valid[!ptr]) begin
      sel_valid = 1'b1;
      sel_idx   = !ptr;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two byte sources onto one UART transmitter. Each accepted byte is
// written with a one-cycle EN pulse (the transmitter captures it on the cycle
// after EN falls), then the block waits SETTLE_CYC cycles before trusting TXBF
// again. Packets (bytes up to last=1) are never interleaved.
module uart_tx_arb
  import uart_pkg::*;
#(
  // Cycles waited after each write before TXBF is re-sampled (1..15).
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           enc_data,
  output logic                 enc_en,
  input  logic [7:0]           enc_rco,
  output logic                 grant,
  output logic                 busy
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q;
  logic [7:0]       enc_data_q;
  logic             run_q;
  logic             ptr_q;
  logic             lock_q;
  logic             grant_q;
  logic             sel_valid;
  logic             sel_idx;
  logic             accept;
  logic [7:0]       acc_data;
  logic             acc_last;
  logic             txbf;
  logic             unused_rco;

  assign txbf       = enc_rco[TXBF_BIT];
  assign unused_rco = ^{enc_rco[7:TXBF_BIT+1], enc_rco[TXBF_BIT-1:0]};

  rr_arb2 u_arb (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .lock      (lock_q),
    .owner     (grant_q),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx)
  );

  assign acc_data = sel_idx ? req_data[15:8] : req_data[7:0];
  assign acc_last = req_last[sel_idx];

  // Reset release is retimed to clk so the FSM never leaves reset mid-cycle;
  // the first accept can happen on the second clock after release.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!nrst) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the accept decision.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_q && !txbf && sel_valid) begin
          accept  = 1'b1;
          state_d = ST_EN_HI;
        end
      end
      ST_EN_HI:  state_d = ST_EN_LO;
      ST_EN_LO:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_q == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Settle counter: loaded as the write cycle ends, counts down in SETTLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      settle_cnt_q <= '0;
    end else if (state_q == ST_EN_LO) begin
      settle_cnt_q <= CNT_W'(SETTLE_CYC - 1);
    end else if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
      settle_cnt_q <= settle_cnt_q - 1'b1;
    end
  end

  // Capture the accepted byte and update ownership, lock and pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      enc_data_q <= '0;
      grant_q    <= 1'b0;
      lock_q     <= 1'b0;
      ptr_q      <= 1'b0;
    end else if (accept) begin
      enc_data_q <= acc_data;
      grant_q    <= sel_idx;
      lock_q     <= !acc_last;
      if (acc_last) ptr_q <= !sel_idx;
    end
  end

  assign req_ready = accept ? req_onehot(sel_idx) : '0;
  assign enc_en    = (state_q == ST_EN_HI);
  assign enc_data  = enc_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: queue-driven byte sources, a scoreboard
// of expected (byte, grant) pairs checked on every EN pulse, plus directed
// timing, lock, back-pressure and reset checks.
module tb_uart_tx_arb;

  localparam int S   = 2;
  localparam int PER = 3 + S;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       g;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic [1:0]  req_ready;
  logic [7:0]  enc_data;
  logic        enc_en;
  logic [7:0]  enc_rco;
  logic        grant;
  logic        busy;

  beat_t src0_q[$];
  beat_t src1_q[$];
  exp_t  exp_q[$];
  int    en_times[$];
  exp_t  mon_e;
  logic [1:0] hs = '0;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  uart_tx_arb #(.SETTLE_CYC(S)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .enc_data  (enc_data),
    .enc_en    (enc_en),
    .enc_rco   (enc_rco),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (r == 0) src0_q.push_back(b);
    else        src1_q.push_back(b);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic g);
    exp_t e;
    e.d = d;
    e.g = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_sb(input int left, input int budget);
    int n = 0;
    while (exp_q.size() > left && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sb_wait", exp_q.size(), left);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Byte sources: retire the head after a handshake, present the next one.
  always @(posedge clk) begin
    #1;
    if (hs[0] && src0_q.size() != 0) src0_q.delete(0);
    if (hs[1] && src1_q.size() != 0) src1_q.delete(0);
    req_valid = {src1_q.size() != 0, src0_q.size() != 0};
    req_data  = {(src1_q.size() != 0) ? src1_q[0].d : 8'h00,
                 (src0_q.size() != 0) ? src0_q[0].d : 8'h00};
    req_last  = {(src1_q.size() != 0) ? src1_q[0].l : 1'b0,
                 (src0_q.size() != 0) ? src0_q[0].l : 1'b0};
  end

  // Monitor: note handshakes; on each EN pulse compare against the scoreboard.
  always @(negedge clk) begin
    hs = req_ready & req_valid;
    if (enc_en === 1'b1) begin
      check("ready_in_en", req_ready, 0);
      check("sb_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("enc_data", enc_data, mon_e.d);
        check("grant", grant, mon_e.g);
      end
      en_times.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    nrst    = 1'b0;
    enc_rco = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_en", enc_en, 0);
    check("rst_data", enc_data, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte timing.
    load(0, 8'h41, 1'b1);
    expect_byte(8'h41, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready === 2'b00 && n < 10);
    check("single_ready", req_ready, 2'b01);
    for (int k = 1; k <= PER; k++) begin
      @(negedge clk);
      check("single_en", enc_en, (k == 1));
      check("single_data", enc_data, 8'h41);
      check("single_busy", busy, (k < PER));
    end
    wait_sb(0, 5);

    // Tie: pointer starts at 0 after reset, then alternates.
    do_reset();
    n0 = en_times.size();
    for (int i = 0; i < 3; i++) begin
      load(0, 8'hAA, 1'b1);
      load(1, 8'h55, 1'b1);
      expect_byte(8'hAA, 1'b0);
      expect_byte(8'h55, 1'b1);
    end
    wait_sb(0, 100);
    check("tie_count", en_times.size() - n0, 6);
    for (int i = 1; i < 6 && n0 + i < en_times.size(); i++)
      check("tie_period", en_times[n0+i] - en_times[n0+i-1], PER);
    wait_idle(20);

    // Packet lock: move the pointer to 1, then req0 starts a packet alone and
    // keeps the transmitter until its last byte even though req1 joins.
    load(0, 8'h10, 1'b1);
    expect_byte(8'h10, 1'b0);
    wait_sb(0, 30);
    wait_idle(20);
    load(0, 8'h01, 1'b0);
    load(0, 8'h02, 1'b1);
    expect_byte(8'h01, 1'b0);
    expect_byte(8'h02, 1'b0);
    expect_byte(8'h77, 1'b1);
    expect_byte(8'h78, 1'b1);
    wait_sb(3, 30);
    load(1, 8'h77, 1'b1);
    load(1, 8'h78, 1'b1);
    wait_sb(0, 100);
    wait_idle(20);

    // Owner stalls mid-packet: lock holds, other requester is ignored.
    load(0, 8'h31, 1'b0);
    expect_byte(8'h31, 1'b0);
    expect_byte(8'h32, 1'b0);
    expect_byte(8'h90, 1'b1);
    wait_sb(2, 30);
    load(1, 8'h90, 1'b1);
    repeat (30) begin
      @(negedge clk);
      check("lock_hold_ready", req_ready, 0);
    end
    check("lock_hold_busy", busy, 1);
    check("lock_hold_grant", grant, 0);
    check("lock_pending", exp_q.size(), 2);
    load(0, 8'h32, 1'b1);
    wait_sb(0, 100);
    wait_idle(20);

    // Transmitter full: nothing moves until TXBF drops; other status bits ignored.
    enc_rco = 8'hFF;
    load(1, 8'hC3, 1'b1);
    expect_byte(8'hC3, 1'b1);
    repeat (20) begin
      @(negedge clk);
      check("full_ready", req_ready, 0);
      check("full_en", enc_en, 0);
    end
    @(posedge clk);
    #1 enc_rco = 8'hBF;
    @(negedge clk);
    check("full_release_ready", req_ready, 2'b10);
    wait_sb(0, 20);
    wait_idle(20);

    // Reset during EN_HI aborts the write; reset release is retimed.
    load(1, 8'hE7, 1'b1);
    expect_byte(8'hE7, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (enc_en !== 1'b1 && n < 20);
    check("abort_enhi", enc_en, 1);
    #1 nrst = 1'b0;
    #1;
    check("abort_en", enc_en, 0);
    check("abort_data", enc_data, 0);
    check("abort_ready", req_ready, 0);
    check("abort_grant", grant, 0);
    check("abort_busy", busy, 0);
    load(0, 8'h5A, 1'b1);
    expect_byte(8'h5A, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_en", enc_en, 0);
    end
    nrst = 1'b1;
    #1;
    check("release_ready0", req_ready, 0);
    @(negedge clk);
    check("release_ready1", req_ready, 2'b01);
    wait_sb(0, 20);
    wait_idle(20);

    check("sb_final", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter SETTLE_CYC, default 1, cycles waited after each write before re-sampling TXBF (range 1..15).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 nrst  input  1  reset, asynchronous assertion, active-low.
REQ-004 req_valid  input  2  per-requester byte valid (bit0 core store path, bit1 debug path).
REQ-005 req_data  input  16  per-requester byte; [7:0] requester 0, [15:8] requester 1.
REQ-006 req_last  input  2  per-requester end-of-packet flag, qualified by req_valid.
REQ-007 req_ready  output  2  one-hot accept pulse; byte transferred when valid and ready are both high.
REQ-008 enc_data  output  8  byte to transmitter data_in.
REQ-009 enc_en  output  1  transmitter EN; the transmitter writes its buffer on the cycle after EN falls.
REQ-010 enc_rco  input  8  transmitter status; [6] TXBF used, other bits ignored.
REQ-011 grant  output  1  index of the requester owning the current/last packet.
REQ-012 busy  output  1  high in any state other than IDLE, or while a packet lock is held.

Function
REQ-013 FSM states: IDLE, EN_HI, EN_LO, SETTLE.
REQ-014 IDLE: when enc_rco[6]=0 and a selected requester is valid, pulse req_ready for that requester, latch its data into enc_data, go to EN_HI; otherwise stay.
REQ-015 IDLE with enc_rco[6]=1: req_ready=0, no latch, stay in IDLE.
REQ-016 EN_HI: enc_en=1 for exactly one cycle, then EN_LO.
REQ-017 EN_LO: enc_en=0 for one cycle (the transmitter write cycle), then SETTLE.
REQ-018 SETTLE: counter loads SETTLE_CYC-1 and decrements; IDLE when it reaches 0.
REQ-019 enc_data changes only on an accept; it is held stable from EN_HI through SETTLE.
REQ-020 Minimum byte period = 3+SETTLE_CYC cycles; at most one accept per period.
REQ-021 Selection when unlocked: the requester indicated by the round-robin pointer wins ties; a lone valid requester wins regardless of the pointer.
REQ-022 Lock: accepting a byte with last=0 locks grant to that requester; only it is served until a byte with last=1 is accepted.
REQ-023 While locked, a valid from the other requester is ignored (req_ready stays 0).
REQ-024 Pointer: on acceptance of a last=1 byte, the pointer moves to the other requester and the lock clears.
REQ-025 A locked owner dropping valid mid-packet keeps the lock; the block waits in IDLE indefinitely.
REQ-026 req_ready is never asserted in EN_HI, EN_LO or SETTLE.

Reset
REQ-027 On nrst low, immediately: state=IDLE, enc_en=0, enc_data=0, req_ready=0, pointer=0, lock=0, grant=0, SETTLE counter=0.
REQ-028 Reset asserted in EN_HI aborts the byte; the requester is not re-notified and the byte is lost.
REQ-029 Reset release is synchronised internally; first accept possible on the second clock after release.

Structure
REQ-030 A shared uart package holds the FSM state encoding, the TXBF bit index (6) and the requester count (2).
REQ-031 One sub-module, rr_arb2 (2-way round-robin select with lock input), is natural; the FSM lives in uart_tx_arb.

Verification
REQ-032 Single byte: req0 valid, data 0x41, last=1, TXBF=0 -> ready0 pulses at cycle 0; enc_en high at cycle 1 only; enc_data=0x41 through cycle 3+SETTLE_CYC; back in IDLE at cycle 3+SETTLE_CYC.
REQ-033 Tie: both valid with last=1 (0xAA and 0x55) -> bytes accepted in order 0xAA, 0x55, 0xAA, ... alternating grant 0,1,0.
REQ-034 Packet lock: req0 sends 0x01 (last=0), 0x02 (last=1) while req1 is continuously valid -> enc_data sequence 0x01, 0x02, then req1's byte.
REQ-035 Full: TXBF=1 with req1 valid -> no ready and enc_en=0 for 20 cycles; TXBF=0 -> accept on the next cycle.
REQ-036 Reset in EN_HI: assert nrst low -> enc_en=0 the same cycle, all outputs at reset values; no write pulse is produced.
